// File: rtl/buffet_seq_pkg.sv
// Shared types and default widths for the buffet read sequencer.
// Optional feature macro used by the top level: BUFFET_SEQ_UPDATE_EN.
package buffet_seq_pkg;

    localparam int DEF_IDX_WIDTH = 8;
    localparam int DEF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_SHRINK = 2'd2,
        ST_FIN    = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [DEF_IDX_WIDTH-1:0] window;
        logic [DEF_CNT_WIDTH-1:0] reuse;
        logic [DEF_IDX_WIDTH-1:0] shrink;
        logic [DEF_CNT_WIDTH-1:0] num_tiles;
    } seq_desc_t;

endpackage

// File: rtl/buffet_seq_walk.sv
// Nested index/pass counter for one tile: idx runs 0..window-1, and each
// wrap of idx advances pass through 0..reuse-1.
module buffet_seq_walk
    import buffet_seq_pkg::*;
#(
    parameter int IDX_WIDTH = DEF_IDX_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 nreset_i,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [IDX_WIDTH-1:0] window,
    input  logic [CNT_WIDTH-1:0] reuse,
    output logic [IDX_WIDTH-1:0] idx,
    output logic [CNT_WIDTH-1:0] pass,
    output logic                 last_idx,
    output logic                 last_pass
);

    // window and reuse are nonzero whenever advance can fire, so the
    // minus-one compares never wrap below zero.
    assign last_idx  = (idx  == (window - IDX_WIDTH'(1)));
    assign last_pass = (pass == (reuse  - CNT_WIDTH'(1)));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!nreset_i || clear) begin
            idx  <= '0;
            pass <= '0;
        end else if (advance) begin
            if (last_idx) begin
                idx  <= '0;
                pass <= last_pass ? '0 : pass + CNT_WIDTH'(1);
            end else begin
                idx  <= idx + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/buffet_read_sequencer.sv
// Drives the buffet read/shrink request channel from a tile descriptor.
// Define BUFFET_SEQ_UPDATE_EN to add cfg_update and drive read_will_update.
module buffet_read_sequencer
    import buffet_seq_pkg::*;
#(
    parameter int IDX_WIDTH = DEF_IDX_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 nreset_i,
    input  logic [IDX_WIDTH-1:0] cfg_window,
    input  logic [CNT_WIDTH-1:0] cfg_reuse,
    input  logic [IDX_WIDTH-1:0] cfg_shrink,
    input  logic [CNT_WIDTH-1:0] cfg_num_tiles,
`ifdef BUFFET_SEQ_UPDATE_EN
    input  logic                 cfg_update,
`endif
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [IDX_WIDTH-1:0] read_idx,
    output logic                 read_idx_valid,
    input  logic                 read_idx_ready,
    output logic                 read_will_update,
    output logic                 is_shrink,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_READ   = ST_READ;
    localparam logic [1:0] S_SHRINK = ST_SHRINK;
    localparam logic [1:0] S_FIN    = ST_FIN;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [IDX_WIDTH-1:0] window_q;
    logic [CNT_WIDTH-1:0] reuse_q;
    logic [IDX_WIDTH-1:0] shrink_q;
    logic [CNT_WIDTH-1:0] tiles_q;
    logic [CNT_WIDTH-1:0] tile_cnt;

    logic [IDX_WIDTH-1:0] idx_cnt;
    logic [CNT_WIDTH-1:0] pass_cnt;
    logic                 last_idx;
    logic                 last_pass;

    logic cfg_fire;
    logic req_fire;
    logic desc_empty;
    logic last_tile;
    logic tile_end;

    assign cfg_fire   = cfg_valid & cfg_ready;
    assign req_fire   = read_idx_valid & read_idx_ready;
    assign desc_empty = (cfg_window == '0) || (cfg_reuse == '0) || (cfg_num_tiles == '0);
    assign last_tile  = (tile_cnt == (tiles_q - CNT_WIDTH'(1)));

    // A tile retires on its shrink, or on its final read when no shrink is issued.
    assign tile_end = ((state == S_READ) && req_fire && last_idx && last_pass && (shrink_q == '0))
                   || ((state == S_SHRINK) && req_fire);

    buffet_seq_walk #(
        .IDX_WIDTH (IDX_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_walk (
        .clk       (clk),
        .nreset_i  (nreset_i),
        .clear     (cfg_fire),
        .advance   ((state == S_READ) && req_fire),
        .window    (window_q),
        .reuse     (reuse_q),
        .idx       (idx_cnt),
        .pass      (pass_cnt),
        .last_idx  (last_idx),
        .last_pass (last_pass)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:   if (cfg_fire) state_nxt = desc_empty ? S_FIN : S_READ;
            S_READ: begin
                if (req_fire && last_idx && last_pass) begin
                    if (shrink_q != '0) state_nxt = S_SHRINK;
                    else                state_nxt = last_tile ? S_FIN : S_READ;
                end
            end
            S_SHRINK: if (req_fire) state_nxt = last_tile ? S_FIN : S_READ;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset_i) begin
            state    <= S_IDLE;
            window_q <= '0;
            reuse_q  <= '0;
            shrink_q <= '0;
            tiles_q  <= '0;
            tile_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_fire) begin
                window_q <= cfg_window;
                reuse_q  <= cfg_reuse;
                shrink_q <= cfg_shrink;
                tiles_q  <= cfg_num_tiles;
                tile_cnt <= '0;
            end else if (tile_end) begin
                tile_cnt <= tile_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef BUFFET_SEQ_UPDATE_EN
    logic update_q;

    always_ff @(posedge clk) begin
        if (!nreset_i)     update_q <= 1'b0;
        else if (cfg_fire) update_q <= cfg_update;
    end

    // Only the final pass of a tile carries update intent; shrinks never do.
    assign read_will_update = (state == S_READ) && last_pass && update_q;
`else
    assign read_will_update = 1'b0;
`endif

    // Outputs decode straight from state, so they hold steady while stalled.
    assign cfg_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_FIN);
    assign read_idx_valid = (state == S_READ) || (state == S_SHRINK);
    assign is_shrink      = (state == S_SHRINK);
    assign read_idx       = (state == S_SHRINK) ? shrink_q :
                            (state == S_READ)   ? idx_cnt  : '0;

endmodule
